// File: rtl/regfile_rd_ctrl_if.sv
// Operand-fetch bundle: decode request, register-file read port, writeback snoop, execute output.
// master = the read controller's view, slave = the surrounding pipeline and register file.
interface regfile_rd_ctrl_if #(
  parameter int XW = 32,
  parameter int TW = 8
) ();
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [TW-1:0] req_tag;
  logic [4:0]    rf_rd_addr1;
  logic [4:0]    rf_rd_addr2;
  logic [XW-1:0] rf_rd_data1;
  logic [XW-1:0] rf_rd_data2;
  logic          wb_wr_en;
  logic [4:0]    wb_wr_addr;
  logic [XW-1:0] wb_wr_data;
  logic          op_valid;
  logic          op_ready;
  logic [XW-1:0] op_rs1_data;
  logic [XW-1:0] op_rs2_data;
  logic [TW-1:0] op_tag;

  modport master (
    input  flush, req_valid, req_rs1, req_rs2, req_tag,
    input  rf_rd_data1, rf_rd_data2, wb_wr_en, wb_wr_addr, wb_wr_data, op_ready,
    output req_ready, rf_rd_addr1, rf_rd_addr2, op_valid, op_rs1_data, op_rs2_data, op_tag
  );

  modport slave (
    output flush, req_valid, req_rs1, req_rs2, req_tag,
    output rf_rd_data1, rf_rd_data2, wb_wr_en, wb_wr_addr, wb_wr_data, op_ready,
    input  req_ready, rf_rd_addr1, rf_rd_addr2, op_valid, op_rs1_data, op_rs2_data, op_tag
  );
endinterface

// File: rtl/regfile_rd_ctrl.sv
// Register-file read initiator: S1 waits out the 1-cycle RF latency with writeback forwarding,
// S2 presents operands to execute and keeps them coherent with writes while held.
module regfile_rd_ctrl #(
  parameter int XW = 32,
  parameter int TW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_rd_ctrl_if.master bus
);

  logic          s1_valid, s2_valid;
  logic [4:0]    s1_rs1, s1_rs2, s2_rs1, s2_rs2;
  logic [TW-1:0] s1_tag, s2_tag;
  logic [XW-1:0] s2_d1, s2_d2;
  logic          wbq_en;
  logic [4:0]    wbq_addr;
  logic [XW-1:0] wbq_data;

  logic          s2_free, s1_adv, s2_hold, req_fire;
  logic [XW-1:0] s1_d1, s1_d2;

  // The RF misses both the write landing this cycle and the one that landed last edge.
  function automatic logic [XW-1:0] fwd(
    input logic [4:0]    rs,
    input logic [XW-1:0] rf_data,
    input logic          c_en,
    input logic [4:0]    c_addr,
    input logic [XW-1:0] c_data,
    input logic          p_en,
    input logic [4:0]    p_addr,
    input logic [XW-1:0] p_data
  );
    if (rs == 5'd0) return '0;
    if (c_en && c_addr == rs) return c_data;
    if (p_en && p_addr == rs) return p_data;
    return rf_data;
  endfunction

  function automatic logic [XW-1:0] refresh(
    input logic [4:0]    rs,
    input logic [XW-1:0] held,
    input logic          w_en,
    input logic [4:0]    w_addr,
    input logic [XW-1:0] w_data
  );
    if (w_en && rs != 5'd0 && w_addr == rs) return w_data;
    return held;
  endfunction

  always_comb begin
    s2_free  = !s2_valid || bus.op_ready;
    s1_adv   = s1_valid && s2_free;
    s2_hold  = s2_valid && !bus.op_ready;
    req_fire = bus.req_valid && bus.req_ready;
    s1_d1    = fwd(s1_rs1, bus.rf_rd_data1, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_wr_data,
                   wbq_en, wbq_addr, wbq_data);
    s1_d2    = fwd(s1_rs2, bus.rf_rd_data2, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_wr_data,
                   wbq_en, wbq_addr, wbq_data);
  end

  assign bus.req_ready   = !bus.flush && (!s1_valid || s1_adv);
  // A stalled S1 keeps re-reading so its data stays one cycle fresh when it finally moves.
  assign bus.rf_rd_addr1 = (s1_valid && !s1_adv) ? s1_rs1 : bus.req_rs1;
  assign bus.rf_rd_addr2 = (s1_valid && !s1_adv) ? s1_rs2 : bus.req_rs2;
  assign bus.op_valid    = s2_valid;
  assign bus.op_rs1_data = s2_d1;
  assign bus.op_rs2_data = s2_d2;
  assign bus.op_tag      = s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_tag   <= '0;
      s2_rs1   <= '0;
      s2_rs2   <= '0;
      s2_tag   <= '0;
      s2_d1    <= '0;
      s2_d2    <= '0;
      wbq_en   <= 1'b0;
      wbq_addr <= '0;
      wbq_data <= '0;
    end else begin
      wbq_en   <= bus.wb_wr_en;
      wbq_addr <= bus.wb_wr_addr;
      wbq_data <= bus.wb_wr_data;

      if (bus.flush)     s1_valid <= 1'b0;
      else if (req_fire) s1_valid <= 1'b1;
      else if (s1_adv)   s1_valid <= 1'b0;

      if (req_fire) begin
        s1_rs1 <= bus.req_rs1;
        s1_rs2 <= bus.req_rs2;
        s1_tag <= bus.req_tag;
      end

      if (bus.flush)        s2_valid <= 1'b0;
      else if (s1_adv)      s2_valid <= 1'b1;
      else if (bus.op_ready) s2_valid <= 1'b0;

      if (s1_adv) begin
        s2_rs1 <= s1_rs1;
        s2_rs2 <= s1_rs2;
        s2_tag <= s1_tag;
        s2_d1  <= s1_d1;
        s2_d2  <= s1_d2;
      end else if (s2_hold) begin
        s2_d1 <= refresh(s2_rs1, s2_d1, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_wr_data);
        s2_d2 <= refresh(s2_rs2, s2_d2, bus.wb_wr_en, bus.wb_wr_addr, bus.wb_wr_data);
      end
    end
  end

endmodule
